// File: rtl/sram_arbiter_pkg.sv
// Shared memory-bus wire types plus the arbiter's state, grant and pending-slot types.
package sram_arbiter_pkg;

   typedef struct packed {
      logic        mem_valid;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic [3:0]  mem_wstrb;
   } mem_in_type;

   typedef struct packed {
      logic        mem_ready;
      logic [31:0] mem_rdata;
      logic        mem_error;
   } mem_out_type;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      GNT_INSTR = 1'b0,
      GNT_DATA  = 1'b1
   } grant_t;

   typedef struct packed {
      logic        pend;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } pend_slot_t;

   // Data wins when it alone is pending, under data priority, or when instruction won last.
   function automatic grant_t pick_grant(input logic data_prio, input logic i_pend,
                                         input logic d_pend, input grant_t last);
      grant_t g;
      if (d_pend && (data_prio || !i_pend || (last == GNT_INSTR))) begin
         g = GNT_DATA;
      end else begin
         g = GNT_INSTR;
      end
      return g;
   endfunction

endpackage

// File: rtl/sram_arbiter_slot.sv
// One pending-request slot: captures a one-cycle mem_valid, holds it until cleared.
module sram_arbiter_slot
   import sram_arbiter_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  mem_in_type req,
   input  logic       clear,
   output pend_slot_t slot
);

   pend_slot_t slot_q;
   pend_slot_t slot_d;

   // Clear first so a request arriving with its own response is kept as the next one.
   always_comb begin
      slot_d = slot_q;
      if (clear) begin
         slot_d.pend = 1'b0;
      end else begin
         slot_d.pend = slot_q.pend;
      end
      if (req.mem_valid && !slot_d.pend) begin
         slot_d.pend  = 1'b1;
         slot_d.addr  = req.mem_addr;
         slot_d.wdata = req.mem_wdata;
         slot_d.wstrb = req.mem_wstrb;
      end else begin
         slot_d.addr  = slot_d.addr;
      end
   end

   // Slot register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot = slot_q;

endmodule

// File: rtl/sram_arbiter.sv
// Two-requester SRAM arbiter: instruction and data ports share one SRAM controller.
module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int dpriority = 0
)
(
   input  logic        clock,
   input  logic        reset,
   input  mem_in_type  imem_in,
   output mem_out_type imem_out,
   input  mem_in_type  dmem_in,
   output mem_out_type dmem_out,
   output mem_in_type  sram_in,
   input  mem_out_type sram_out
);

   localparam logic DPRIO = (dpriority != 0) ? 1'b1 : 1'b0;

   arb_state_t state_q, state_d;
   grant_t     grant_q, grant_d;
   grant_t     last_q, last_d;
   mem_in_type sram_q, sram_d;
   pend_slot_t i_slot, d_slot;
   logic       i_clear, d_clear;
   logic       resp_s;

   sram_arbiter_slot u_islot (
      .clock (clock),
      .reset (reset),
      .req   (imem_in),
      .clear (i_clear),
      .slot  (i_slot)
   );

   sram_arbiter_slot u_dslot (
      .clock (clock),
      .reset (reset),
      .req   (dmem_in),
      .clear (d_clear),
      .slot  (d_slot)
   );

   // Grant FSM next-state; sram_in is registered so mem_valid lasts exactly the ISSUE cycle.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      sram_d  = sram_q;
      i_clear = 1'b0;
      d_clear = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_slot.pend || d_slot.pend) begin
               grant_d          = pick_grant(DPRIO, i_slot.pend, d_slot.pend, last_q);
               state_d          = ST_ISSUE;
               sram_d.mem_valid = 1'b1;
               if (grant_d == GNT_DATA) begin
                  sram_d.mem_addr  = d_slot.addr;
                  sram_d.mem_wdata = d_slot.wdata;
                  sram_d.mem_wstrb = d_slot.wstrb;
               end else begin
                  sram_d.mem_addr  = i_slot.addr;
                  sram_d.mem_wdata = i_slot.wdata;
                  sram_d.mem_wstrb = i_slot.wstrb;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d          = ST_WAIT;
            sram_d.mem_valid = 1'b0;
         end
         ST_WAIT: begin
            if (sram_out.mem_ready) begin
               state_d = ST_IDLE;
               last_d  = grant_q;
               if (grant_q == GNT_DATA) begin
                  d_clear = 1'b1;
               end else begin
                  i_clear = 1'b1;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         default: begin
            state_d          = ST_IDLE;
            sram_d.mem_valid = 1'b0;
         end
      endcase
   end

   // FSM and request-output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         grant_q <= GNT_INSTR;
         last_q  <= GNT_INSTR;
         sram_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         sram_q  <= sram_d;
      end
   end

   assign sram_in = sram_q;
   assign resp_s  = (state_q == ST_WAIT) && sram_out.mem_ready;

   // Response forwarding is combinational so the requester sees ready in the SRAM ready cycle.
   always_comb begin
      imem_out.mem_error = sram_out.mem_error;
      dmem_out.mem_error = sram_out.mem_error;
      if (resp_s && (grant_q == GNT_INSTR)) begin
         imem_out.mem_ready = 1'b1;
         imem_out.mem_rdata = sram_out.mem_rdata;
      end else begin
         imem_out.mem_ready = 1'b0;
         imem_out.mem_rdata = 32'h0000_0000;
      end
      if (resp_s && (grant_q == GNT_DATA)) begin
         dmem_out.mem_ready = 1'b1;
         dmem_out.mem_rdata = sram_out.mem_rdata;
      end else begin
         dmem_out.mem_ready = 1'b0;
         dmem_out.mem_rdata = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench: cycle table for round-robin instance, hand sequences for reset and data priority.
module tb_sram_arbiter;
   import sram_arbiter_pkg::*;

   logic        clk;
   logic        reset;
   mem_in_type  i0_in, d0_in, s0_in, i1_in, d1_in, s1_in;
   mem_out_type i0_out, d0_out, s0_out, i1_out, d1_out, s1_out;

   int n_checks = 0;
   int n_errors = 0;

   sram_arbiter #(.dpriority(0)) dut0 (
      .clock(clk), .reset(reset),
      .imem_in(i0_in), .imem_out(i0_out),
      .dmem_in(d0_in), .dmem_out(d0_out),
      .sram_in(s0_in), .sram_out(s0_out)
   );

   sram_arbiter #(.dpriority(1)) dut1 (
      .clock(clk), .reset(reset),
      .imem_in(i1_in), .imem_out(i1_out),
      .dmem_in(d1_in), .dmem_out(d1_out),
      .sram_in(s1_in), .sram_out(s1_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic        dv;
      logic [31:0] da;
      logic [31:0] dwd;
      logic [3:0]  dws;
      logic        rdy;
      logic [31:0] rd;
      logic        e_sv;
      logic [31:0] e_sa;
      logic [31:0] e_swd;
      logic [3:0]  e_sws;
      logic        e_ir;
      logic        e_dr;
      logic [31:0] e_ird;
      logic [31:0] e_drd;
   } vec_t;

   vec_t tbl[22];

   function automatic vec_t mkv(logic iv, logic [31:0] ia, logic dv, logic [31:0] da,
                                logic [31:0] dwd, logic [3:0] dws, logic rdy, logic [31:0] rd,
                                logic esv, logic [31:0] esa, logic [31:0] eswd, logic [3:0] esws,
                                logic eir, logic edr, logic [31:0] eird, logic [31:0] edrd);
      vec_t v;
      v.iv = iv; v.ia = ia; v.dv = dv; v.da = da; v.dwd = dwd; v.dws = dws;
      v.rdy = rdy; v.rd = rd; v.e_sv = esv; v.e_sa = esa; v.e_swd = eswd; v.e_sws = esws;
      v.e_ir = eir; v.e_dr = edr; v.e_ird = eird; v.e_drd = edrd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i0_in = '0; d0_in = '0; s0_out = '0;
      i1_in = '0; d1_in = '0; s1_out = '0;
   endtask

   // Advance until the chosen instance raises sram_in.mem_valid, bounded.
   task automatic wait_issue(input int which, input string name);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         tick();
         seen = (which == 0) ? s0_in.mem_valid : s1_in.mem_valid;
      end
      chk(name, {31'd0, seen}, 32'd1);
   endtask

   initial begin
      clear_inputs();
      reset = 1'b1;

      //    iv    ia            dv    da            dwd           dws   rdy   rd            sv    sa            swd           sws   ir    dr    ird           drd
      tbl[0]  = mkv(1'b1, 32'h40, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[1]  = mkv(1'b1, 32'h80, 1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[2]  = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[3]  = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 32'hDEADBEEF);
      tbl[4]  = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'h99,       1'b0, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[5]  = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'h98,       1'b1, 32'h40,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[6]  = mkv(1'b1, 32'h88, 1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'h11110000, 1'b0, 32'h40,  32'h0, 4'h0, 1'b1, 1'b0, 32'h11110000, 32'h0);
      tbl[7]  = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h40,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[8]  = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h88,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[9]  = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'h22,       1'b0, 32'h88,  32'h0, 4'h0, 1'b1, 1'b0, 32'h22, 32'h0);
      tbl[10] = mkv(1'b0, 32'h0,  1'b1, 32'h204, 32'h12345678, 4'hC, 1'b0, 32'h0, 1'b0, 32'h88,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[11] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h88,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[12] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h204, 32'h12345678, 4'hC, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[13] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'h33,       1'b0, 32'h204, 32'h12345678, 4'hC, 1'b0, 1'b1, 32'h0, 32'h33);
      tbl[14] = mkv(1'b1, 32'h44, 1'b1, 32'h304, 32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h204, 32'h12345678, 4'hC, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[15] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h204, 32'h12345678, 4'hC, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[16] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h44,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[17] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'h55,       1'b0, 32'h44,  32'h0, 4'h0, 1'b1, 1'b0, 32'h55, 32'h0);
      tbl[18] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h44,  32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[19] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h304, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      tbl[20] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b1, 32'h66,       1'b0, 32'h304, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0, 32'h66);
      tbl[21] = mkv(1'b0, 32'h0,  1'b0, 32'h0,   32'h0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h304, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      tick();
      tick();
      chk("reset_sv", {31'd0, s0_in.mem_valid}, 32'd0);
      chk("reset_sa", s0_in.mem_addr, 32'h0);
      reset = 1'b0;

      // Round-robin instance, one table row per clock cycle.
      for (int i = 0; i < 22; i++) begin
         i0_in.mem_valid  = tbl[i].iv;
         i0_in.mem_addr   = tbl[i].ia;
         d0_in.mem_valid  = tbl[i].dv;
         d0_in.mem_addr   = tbl[i].da;
         d0_in.mem_wdata  = tbl[i].dwd;
         d0_in.mem_wstrb  = tbl[i].dws;
         s0_out.mem_ready = tbl[i].rdy;
         s0_out.mem_rdata = tbl[i].rd;
         #1;
         chk($sformatf("row%0d_sram_valid", i), {31'd0, s0_in.mem_valid}, {31'd0, tbl[i].e_sv});
         chk($sformatf("row%0d_sram_addr", i), s0_in.mem_addr, tbl[i].e_sa);
         chk($sformatf("row%0d_sram_wdata", i), s0_in.mem_wdata, tbl[i].e_swd);
         chk($sformatf("row%0d_sram_wstrb", i), {28'd0, s0_in.mem_wstrb}, {28'd0, tbl[i].e_sws});
         chk($sformatf("row%0d_i_ready", i), {31'd0, i0_out.mem_ready}, {31'd0, tbl[i].e_ir});
         chk($sformatf("row%0d_d_ready", i), {31'd0, d0_out.mem_ready}, {31'd0, tbl[i].e_dr});
         chk($sformatf("row%0d_i_rdata", i), i0_out.mem_rdata, tbl[i].e_ird);
         chk($sformatf("row%0d_d_rdata", i), d0_out.mem_rdata, tbl[i].e_drd);
         tick();
      end
      clear_inputs();

      // Reset while waiting on the SRAM, then a late response must be dropped.
      d0_in.mem_valid = 1'b1;
      d0_in.mem_addr  = 32'h500;
      tick();
      clear_inputs();
      tick();
      chk("rst_pre_issue", {31'd0, s0_in.mem_valid}, 32'd1);
      chk("rst_pre_addr", s0_in.mem_addr, 32'h500);
      tick();
      reset = 1'b1;
      s0_out.mem_ready = 1'b1;
      s0_out.mem_rdata = 32'h77;
      #1;
      chk("rst_async_sv", {31'd0, s0_in.mem_valid}, 32'd0);
      chk("rst_async_sa", s0_in.mem_addr, 32'h0);
      chk("rst_d_ready", {31'd0, d0_out.mem_ready}, 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("rst_late_d_ready", {31'd0, d0_out.mem_ready}, 32'd0);
      chk("rst_late_i_ready", {31'd0, i0_out.mem_ready}, 32'd0);
      chk("rst_late_d_rdata", d0_out.mem_rdata, 32'h0);
      tick();
      s0_out.mem_ready = 1'b0;
      #1;
      chk("rst_no_issue", {31'd0, s0_in.mem_valid}, 32'd0);
      d0_in.mem_valid = 1'b1;
      d0_in.mem_addr  = 32'h600;
      tick();
      clear_inputs();
      wait_issue(0, "rst_next_issue");
      chk("rst_next_addr", s0_in.mem_addr, 32'h600);
      tick();
      s0_out.mem_ready = 1'b1;
      s0_out.mem_rdata = 32'hABCD;
      #1;
      chk("rst_next_d_ready", {31'd0, d0_out.mem_ready}, 32'd1);
      chk("rst_next_d_rdata", d0_out.mem_rdata, 32'hABCD);
      tick();
      clear_inputs();

      // Data-priority instance: data re-requests on each response, instruction waits.
      i1_in.mem_valid = 1'b1;
      i1_in.mem_addr  = 32'h2000;
      d1_in.mem_valid = 1'b1;
      d1_in.mem_addr  = 32'h1000;
      tick();
      clear_inputs();
      for (int r = 0; r < 4; r++) begin
         wait_issue(1, $sformatf("dprio_issue%0d", r));
         chk($sformatf("dprio_addr%0d", r), s1_in.mem_addr, 32'h1000 + 32'(4 * r));
         tick();
         s1_out.mem_ready = 1'b1;
         s1_out.mem_rdata = 32'(r);
         if (r < 3) begin
            d1_in.mem_valid = 1'b1;
            d1_in.mem_addr  = 32'h1000 + 32'(4 * (r + 1));
         end else begin
            d1_in.mem_valid = 1'b0;
         end
         #1;
         chk($sformatf("dprio_d_ready%0d", r), {31'd0, d1_out.mem_ready}, 32'd1);
         chk($sformatf("dprio_i_ready%0d", r), {31'd0, i1_out.mem_ready}, 32'd0);
         tick();
         clear_inputs();
      end
      wait_issue(1, "dprio_instr_issue");
      chk("dprio_instr_addr", s1_in.mem_addr, 32'h2000);
      tick();
      s1_out.mem_ready = 1'b1;
      s1_out.mem_rdata = 32'h5A5A;
      #1;
      chk("dprio_instr_ready", {31'd0, i1_out.mem_ready}, 32'd1);
      chk("dprio_instr_rdata", i1_out.mem_rdata, 32'h5A5A);
      tick();
      clear_inputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
